// File: rtl/trdb_packet_arbiter.sv
// Round-robin arbiter merging NREQ multi-beat trace-packet streams into one registered stream.
// A winning requester keeps the output until its last beat is accepted.
module trdb_packet_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*DATA_W-1:0] req_data_i,
    input  logic [NREQ-1:0]        req_last_i,
    output logic [NREQ-1:0]        req_ready_o,
    output logic                   valid_o,
    output logic [DATA_W-1:0]      data_o,
    output logic [IDX_W-1:0]       idx_o,
    output logic                   last_o,
    input  logic                   ready_i
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [IDX_W-1:0]   r_lock_idx;
    logic [IDX_W-1:0]   w_lock_d;
    logic [NREQ-1:0]    r_prio_mask;
    logic [NREQ-1:0]    w_mask_d;
    logic               r_valid;
    logic [DATA_W-1:0]  r_data;
    logic [IDX_W-1:0]   r_idx;
    logic               r_last;

    logic               w_load_en;
    logic [NREQ-1:0]    w_masked;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_grant_en;
    logic [NREQ-1:0]    w_ready;
    logic               w_fire;
    logic [DATA_W-1:0]  w_data;
    logic               w_last;

    // Trailing-zero count: index of the lowest set bit (0 when empty).
    function automatic logic [IDX_W-1:0] f_tzc(input logic [NREQ-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Priority goes to indices strictly above the one that just finished.
    function automatic logic [NREQ-1:0] f_mask_above(input logic [IDX_W-1:0] k);
        logic [NREQ-1:0] m;
        for (int j = 0; j < int'(NREQ); j++) begin
            m[j] = (j > int'(k));
        end
        if (int'(k) == int'(NREQ) - 1) m = '1;
        return m;
    endfunction

    assign w_load_en = ~r_valid | ready_i;
    assign w_masked  = req_valid_i & r_prio_mask;

    always_comb begin
        w_grant_idx = r_lock_idx;
        w_grant_en  = 1'b1;
        if (r_state == StIdle) begin
            w_grant_idx = (|w_masked) ? f_tzc(w_masked) : f_tzc(req_valid_i);
            w_grant_en  = |req_valid_i;
        end
    end

    always_comb begin
        w_ready = '0;
        w_data  = '0;
        w_last  = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_grant_idx == IDX_W'(i)) begin
                w_ready[i] = w_grant_en & w_load_en & ~flush_i;
                w_data     = req_data_i[i*DATA_W +: DATA_W];
                w_last     = req_last_i[i];
            end
        end
    end

    assign w_fire      = |(w_ready & req_valid_i);
    assign req_ready_o = w_ready;

    always_comb begin
        w_state_d = r_state;
        w_lock_d  = r_lock_idx;
        w_mask_d  = r_prio_mask;
        if (flush_i) begin
            w_state_d = StIdle;
        end else if (w_fire) begin
            if (w_last) begin
                w_state_d = StIdle;
                w_mask_d  = f_mask_above(w_grant_idx);
            end else if (r_state == StIdle) begin
                w_state_d = StBurst;
                w_lock_d  = w_grant_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_lock_idx  <= '0;
            r_prio_mask <= '1;
        end else begin
            r_state     <= w_state_d;
            r_lock_idx  <= w_lock_d;
            r_prio_mask <= w_mask_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_load_en) begin
            r_valid <= w_fire;
            if (w_fire) begin
                r_data <= w_data;
                r_idx  <= w_grant_idx;
                r_last <= w_last;
            end
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign idx_o   = r_idx;
    assign last_o  = r_last;

endmodule
